// File: rtl/reg_load_arbiter.sv
// Round-robin arbiter sharing one falling-edge loadable register.
// One registered load pulse per grant, then a 4-phase ack handshake.
module reg_load_arbiter #(
  parameter int N_REQ = 4,
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [N_REQ-1:0]       req,
  input  logic [N_REQ*WIDTH-1:0] req_data,
  output logic [N_REQ-1:0]       grant,
  output logic [N_REQ-1:0]       ack,
  output logic                   load,
  output logic [WIDTH-1:0]       load_data,
  output logic                   busy,
  output logic [CNT_W-1:0]       load_count
);

  localparam int PW = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [1:0] {
    S_IDLE,
    S_LOAD,
    S_ACK
  } state_t;

  state_t           r_state;
  logic [PW-1:0]    r_ptr;
  logic [PW-1:0]    r_idx;
  logic [N_REQ-1:0] r_grant;
  logic [N_REQ-1:0] r_ack;
  logic             r_load;
  logic [WIDTH-1:0] r_load_data;
  logic             r_busy;
  logic [CNT_W-1:0] r_count;

  logic             w_found;
  logic [PW-1:0]    w_idx;
  logic [PW-1:0]    w_nxt;

  // Search starts at the pointer and wraps, giving rotating priority.
  always_comb begin
    w_found = 1'b0;
    w_idx   = '0;
    for (int k = 0; k < N_REQ; k++) begin
      if (!w_found && req[(int'(r_ptr) + k) % N_REQ]) begin
        w_found = 1'b1;
        w_idx   = PW'((int'(r_ptr) + k) % N_REQ);
      end
    end
  end

  assign w_nxt = (r_idx == PW'(N_REQ - 1)) ? '0 : r_idx + 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= S_IDLE;
      r_ptr       <= '0;
      r_idx       <= '0;
      r_grant     <= '0;
      r_ack       <= '0;
      r_load      <= 1'b0;
      r_load_data <= '0;
      r_busy      <= 1'b0;
      r_count     <= '0;
    end else begin
      unique case (r_state)
        S_IDLE: begin
          if (w_found) begin
            r_state     <= S_LOAD;
            r_idx       <= w_idx;
            r_grant     <= N_REQ'(1) << w_idx;
            r_load      <= 1'b1;
            r_load_data <= req_data[w_idx*WIDTH +: WIDTH];
            r_busy      <= 1'b1;
          end
        end
        S_LOAD: begin
          r_state <= S_ACK;
          r_load  <= 1'b0;
          r_ack   <= r_grant;
          r_count <= r_count + 1'b1;
        end
        S_ACK: begin
          if (!req[r_idx]) begin
            r_state <= S_IDLE;
            r_grant <= '0;
            r_ack   <= '0;
            r_ptr   <= w_nxt;
            r_busy  <= 1'b0;
          end
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign grant      = r_grant;
  assign ack        = r_ack;
  assign load       = r_load;
  assign load_data  = r_load_data;
  assign busy       = r_busy;
  assign load_count = r_count;

endmodule
